// File: rtl/sim_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sim_cycle_controller
//  Description : Run sequencer for bench top-levels. Counts clk cycles after
//                start, supports pause/resume/abort, emits a periodic tick
//                strobe and raises finish_req once the cycle budget is spent.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1      system clock, rising edge
//    rst         in   1      asynchronous active-high reset
//    start       in   1      begin a run (honoured in IDLE / DONE)
//    pause       in   1      freeze counting (honoured in RUN)
//    resume      in   1      continue counting (honoured in PAUSE)
//    abort       in   1      terminate the run (honoured in RUN / PAUSE)
//    max_cycles  in   CNT_W  cycle budget, latched on an accepted start
//    cyc         out  CNT_W  cycles counted in the current run
//    running     out  1      state is RUN
//    paused      out  1      state is PAUSE
//    tick        out  1      strobe every TICK_PERIOD counted cycles
//    done        out  1      one-cycle pulse on entry to DONE
//    aborted     out  1      DONE was reached through abort
//    finish_req  out  1      state is DONE
// ============================================================================
module sim_cycle_controller #(
  parameter int CNT_W       = 16,
  parameter int TICK_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             abort,
  input  logic [CNT_W-1:0] max_cycles,
  output logic [CNT_W-1:0] cyc,
  output logic             running,
  output logic             paused,
  output logic             tick,
  output logic             done,
  output logic             aborted,
  output logic             finish_req
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_PERIOD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             running_q, running_d;
  logic             paused_q, paused_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             finish_req_q, finish_req_d;

  logic [CNT_W-1:0] cyc_inc;

  // limit never exceeds 2**CNT_W-1, so this increment cannot wrap
  assign cyc_inc = cyc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    tick_cnt_d = tick_cnt_q;
    limit_d    = limit_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = aborted_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          limit_d    = max_cycles;
          cyc_d      = '0;
          tick_cnt_d = '0;
          aborted_d  = 1'b0;
          if (max_cycles == '0) begin
            // Zero budget: the run is complete before any cycle is counted
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (pause) begin
          // Pause wins over the count, even on the final count edge
          state_d = ST_PAUSE;
        end else begin
          cyc_d = cyc_inc;
          if (tick_cnt_q == c_tick_last) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
          if (cyc_inc == limit_q) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            aborted_d = 1'b0;
          end
        end
      end

      ST_PAUSE: begin
        if (abort) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are derived from the next state so they register with it
    running_d    = (state_d == ST_RUN);
    paused_d     = (state_d == ST_PAUSE);
    finish_req_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      tick_cnt_q   <= '0;
      limit_q      <= '0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      finish_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      tick_cnt_q   <= tick_cnt_d;
      limit_q      <= limit_d;
      running_q    <= running_d;
      paused_q     <= paused_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      finish_req_q <= finish_req_d;
    end
  end

  assign cyc        = cyc_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign tick       = tick_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign finish_req = finish_req_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_cycle_controller
//  Description : Self-checking bench for sim_cycle_controller. A table of
//                per-cycle {inputs, expected outputs} records drives the main
//                scenarios; hand-written sequences cover reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_cycle_controller;

  localparam int CNT_W       = 16;
  localparam int TICK_PERIOD = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             pause;
  logic             resume;
  logic             abort;
  logic [CNT_W-1:0] max_cycles;
  logic [CNT_W-1:0] cyc;
  logic             running;
  logic             paused;
  logic             tick;
  logic             done;
  logic             aborted;
  logic             finish_req;

  int n_checks;
  int n_fail;

  // flags order: {running, paused, tick, done, aborted, finish_req}
  typedef struct {
    logic             st;
    logic             pa;
    logic             re;
    logic             ab;
    logic [CNT_W-1:0] mx;
    logic [CNT_W-1:0] exp_cyc;
    logic [5:0]       exp_flags;
  } vec_t;

  vec_t vecs[$];

  sim_cycle_controller #(
    .CNT_W       (CNT_W),
    .TICK_PERIOD (TICK_PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .resume     (resume),
    .abort      (abort),
    .max_cycles (max_cycles),
    .cyc        (cyc),
    .running    (running),
    .paused     (paused),
    .tick       (tick),
    .done       (done),
    .aborted    (aborted),
    .finish_req (finish_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic st, input logic pa, input logic re, input logic ab,
                     input int mx, input int c, input logic [5:0] fl);
    vec_t v;
    v.st = st; v.pa = pa; v.re = re; v.ab = ab;
    v.mx = CNT_W'(mx);
    v.exp_cyc = CNT_W'(c);
    v.exp_flags = fl;
    vecs.push_back(v);
  endtask

  // Plain counting edges k = first..last of a run with budget lim
  task automatic add_counts(input int first, input int last, input int lim);
    for (int k = first; k <= last; k++) begin
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, k,
          {k != lim, 1'b0, (k % TICK_PERIOD) == 0, k == lim, 1'b0, k == lim});
    end
  endtask

  task automatic check(input string name, input logic [CNT_W-1:0] exp_cyc,
                       input logic [5:0] exp_flags);
    logic [5:0] act;
    act = {running, paused, tick, done, aborted, finish_req};
    n_checks++;
    if (cyc !== exp_cyc || act !== exp_flags) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d flags=%b, expected cyc=%0d flags=%b (run,pau,tick,done,abrt,fin)",
               name, cyc, act, exp_cyc, exp_flags);
    end
  endtask

  task automatic drive(input logic st, input logic pa, input logic re, input logic ab,
                       input logic [CNT_W-1:0] mx);
    start = st; pause = pa; resume = re; abort = ab; max_cycles = mx;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;

    // ---------------- vector table ----------------
    // Control inputs ignored in IDLE
    add(0, 1, 1, 1, 0, 0, 6'b000000);
    // Basic run, budget 10; a start during RUN is ignored
    add(1, 0, 0, 0, 10, 0, 6'b100000);
    add_counts(1, 2, 10);
    add(1, 0, 0, 0, 2, 3, 6'b100000);
    add_counts(4, 10, 10);
    add(0, 0, 0, 0, 0, 10, 6'b000001);
    // Zero budget from DONE
    add(1, 0, 0, 0, 0, 0, 6'b000101);
    add(0, 0, 0, 0, 0, 0, 6'b000001);
    // Restart with budget 3
    add(1, 0, 0, 0, 3, 0, 6'b100000);
    add_counts(1, 3, 3);
    add(0, 0, 0, 0, 0, 3, 6'b000001);
    // Pause at cyc=3 for 5 cycles (start ignored while paused), then resume
    add(1, 0, 0, 0, 10, 0, 6'b100000);
    add_counts(1, 3, 10);
    add(0, 1, 0, 0, 0, 3, 6'b010000);
    add(0, 0, 0, 0, 0, 3, 6'b010000);
    add(1, 0, 0, 0, 5, 3, 6'b010000);
    add(0, 1, 0, 0, 0, 3, 6'b010000);
    add(0, 0, 0, 0, 0, 3, 6'b010000);
    add(0, 0, 1, 0, 0, 3, 6'b100000);
    add_counts(4, 10, 10);
    add(0, 0, 0, 0, 0, 10, 6'b000001);
    // Abort in RUN at cyc=6 (abort beats pause)
    add(1, 0, 0, 0, 10, 0, 6'b100000);
    add_counts(1, 6, 10);
    add(0, 1, 0, 1, 0, 6, 6'b000111);
    add(0, 0, 0, 0, 0, 6, 6'b000011);
    // Abort in PAUSE at cyc=6 (abort beats resume)
    add(1, 0, 0, 0, 10, 0, 6'b100000);
    add_counts(1, 6, 10);
    add(0, 1, 0, 0, 0, 6, 6'b010000);
    add(0, 0, 1, 1, 0, 6, 6'b000111);
    add(0, 0, 0, 0, 0, 6, 6'b000011);
    // Pause coincident with the final count edge
    add(1, 0, 0, 0, 10, 0, 6'b100000);
    add_counts(1, 9, 10);
    add(0, 1, 0, 0, 0, 9, 6'b010000);
    add(0, 0, 1, 0, 0, 9, 6'b100000);
    add_counts(10, 10, 10);
    add(0, 0, 0, 0, 0, 10, 6'b000001);
    // Abort coincident with the final count edge
    add(1, 0, 0, 0, 10, 0, 6'b100000);
    add_counts(1, 9, 10);
    add(0, 0, 0, 1, 0, 9, 6'b000111);
    add(0, 0, 0, 0, 0, 9, 6'b000011);
    // Restart from aborted DONE clears aborted / finish_req
    add(1, 0, 0, 0, 3, 0, 6'b100000);
    add_counts(1, 3, 3);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '0, 6'b000000);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table execution ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].pa, vecs[i].re, vecs[i].ab, vecs[i].mx);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_cyc, vecs[i].exp_flags);
    end

    // ---------------- asynchronous reset mid-run ----------------
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(10));
    @(posedge clk);
    #1;
    check("rst_seq_start", '0, 6'b100000);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_seq_cyc5", CNT_W'(5), 6'b100000);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_clear", '0, 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stays_idle", '0, 6'b000000);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(4));
    @(posedge clk);
    #1;
    check("rst_restart", '0, 6'b100000);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    check("rst_restart_cnt1", CNT_W'(1), 6'b100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_cycle_controller.md
Name: sim_cycle_controller

Overview:
- Sequences a clocked run: counts `clk` cycles after `start`, supports pause/resume/abort, and emits a periodic `tick` strobe.
- Raises `finish_req` after a programmed cycle budget is spent.
- Bench top-levels use it in place of hand-written "if (cyc == N) $finish" logic, driving `$finish` from `finish_req`.

Parameters:
- CNT_W, 16, width of the cycle counter and the budget input.
- TICK_PERIOD, 4, cycles between `tick` pulses; legal range 1 .. 2**CNT_W-1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- pause  in  1  freeze counting; sampled in RUN.
- resume  in  1  continue counting; sampled in PAUSE.
- abort  in  1  terminate the run; sampled in RUN or PAUSE.
- max_cycles  in  CNT_W  cycle budget; latched on an accepted `start`.
- cyc  out  CNT_W  cycles counted in the current run.
- running  out  1  high while in RUN.
- paused  out  1  high while in PAUSE.
- tick  out  1  one-cycle strobe every TICK_PERIOD counted cycles.
- done  out  1  one-cycle pulse on entry to DONE.
- aborted  out  1  high in DONE when DONE was entered via `abort`.
- finish_req  out  1  high in DONE; held until the next `start` or `rst`.

Behaviour:
- All outputs are registered.
- Reset (`rst` high, asynchronous, valid at any time, including mid-run):
  - State IDLE.
  - `cyc`, internal tick counter and latched limit = 0.
  - `running`, `paused`, `tick`, `done`, `aborted`, `finish_req` = 0.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - On `start`: latch `limit` = `max_cycles`; `cyc` <= 0; tick counter <= 0.
  - If `max_cycles` == 0, go directly to DONE (`done` pulse, `cyc` = 0). Otherwise go to RUN.
  - `pause`, `resume` and `abort` are ignored.
- RUN, priority abort > pause > count:
  - abort: go to DONE; `aborted` <= 1; `cyc` holds.
  - pause: go to PAUSE; no increment in that cycle.
  - count:
    - `cyc` <= `cyc` + 1.
    - Tick counter increments. When it equals TICK_PERIOD-1, it wraps to 0 and `tick` <= 1 for one cycle.
    - If `cyc` + 1 == `limit`, go to DONE in the same edge (`done` <= 1, `aborted` <= 0).
  - Latency: `done` is registered on the limit-th counted edge, with `cyc` = `limit` on that same edge.
- PAUSE, priority abort > resume:
  - `cyc`, tick counter and `limit` hold.
  - `tick` = 0.
  - On resume: return to RUN; counting restarts on the following edge.
- DONE:
  - `finish_req` = 1; `cyc` holds its final value.
  - On `start`: restart exactly as from IDLE (new `limit` latched). `finish_req`, `aborted` <= 0 on that edge.
- `done` is high for exactly one cycle per run. `tick` never asserts outside count edges.
- `running` = (state == RUN); `paused` = (state == PAUSE), both registered with the state.
- `cyc` never wraps: `limit` ≤ 2**CNT_W-1, so the run ends before overflow.
- Simultaneous:
  - `start` in RUN or PAUSE is ignored.
  - `pause` with the final count edge: pause wins; the run completes after `resume`.
  - `abort` with the final count edge: abort wins (`aborted` = 1, `cyc` = `limit`-1).

Test Plan:
- Reset, then `start` with `max_cycles` = 10 and TICK_PERIOD = 4:
  - `running` high for 10 cycles; `cyc` steps 1..10.
  - `tick` pulses on the edges where `cyc` becomes 4 and 8.
  - `done` pulses once with `cyc` = 10; `finish_req` stays 1; `aborted` = 0.
- `max_cycles` = 10:
  - `pause` when `cyc` = 3, hold 5 cycles: `cyc` stays 3 and `paused` = 1.
  - `resume`: `done` arrives 7 counted cycles later; total wall cycles = 10 + pause span.
- `max_cycles` = 10, `abort` when `cyc` = 6 (once in RUN, once in PAUSE):
  - DONE entered; `cyc` = 6; `aborted` = 1; `done` pulses once.
- `max_cycles` = 0:
  - `start` → DONE on the next edge; `cyc` = 0; `done` pulse; `tick` never asserts.
- Restart and edge case:
  - From DONE, `start` with `max_cycles` = 3: `finish_req` and `aborted` clear; `cyc` runs 1..3; `done` pulses again.
  - Separately, `pause` with the final count edge at `cyc` = 9: PAUSE with `cyc` = 9, no `done`.
- Assert `rst` when `cyc` = 5 in RUN, asynchronously mid-cycle:
  - All outputs 0 immediately.
  - State IDLE; `start` is required to count again.
